// File: rtl/rps_match_engine.sv
// Best-of match judge for stone/paper/scissors.
// Each start rising edge plays one round: the moves are latched, judged one
// cycle later, and the scores and round counter are updated. The match ends
// when a player reaches WIN_TARGET or MAX_ROUNDS counted rounds are played.
module rps_match_engine #(
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 7,
    parameter int SCORE_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [1:0]         p1_move_i,
    input  logic [1:0]         p2_move_i,
    input  logic               start_i,
    input  logic               clear_i,
    output logic [1:0]         round_result_o,
    output logic               result_valid_o,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic [SCORE_W-1:0] round_cnt_o,
    output logic               match_done_o,
    output logic [1:0]         match_winner_o
);

    typedef enum logic [1:0] {IDLE, EVAL, RESULT, DONE} state_t;

    localparam logic [1:0] RES_TIE = 2'b00;
    localparam logic [1:0] RES_P1  = 2'b01;
    localparam logic [1:0] RES_P2  = 2'b10;
    localparam logic [1:0] RES_INV = 2'b11;

    localparam logic [SCORE_W-1:0] CNT_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_T   = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] MAX_R   = SCORE_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic               start_d_q;
    logic [1:0]         p1m_q, p1m_d, p2m_q, p2m_d;
    logic [1:0]         round_result_q, round_result_d;
    logic               result_valid_q, result_valid_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [SCORE_W-1:0] round_cnt_q, round_cnt_d;
    logic               match_done_q, match_done_d;
    logic [1:0]         match_winner_q, match_winner_d;

    logic               rise;
    logic [1:0]         verdict;
    logic               end_cond;

    // Paper(1) beats stone(0), stone(0) beats scissors(2), scissors(2) beats paper(1).
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b11 || b == 2'b11) return RES_INV;
        if (a == b) return RES_TIE;
        if ((a == 2'd1 && b == 2'd0) || (a == 2'd0 && b == 2'd2) ||
            (a == 2'd2 && b == 2'd1)) return RES_P1;
        return RES_P2;
    endfunction

    assign rise     = start_i & ~start_d_q;
    assign verdict  = judge(p1m_q, p2m_q);
    // Registered scores already hold the post-update values once in RESULT.
    assign end_cond = (p1_score_q == WIN_T) || (p2_score_q == WIN_T) ||
                      (round_cnt_q == MAX_R);

    // Next-state and output decode; clear overrides everything, including a rise.
    always_comb begin
        state_d        = state_q;
        p1m_d          = p1m_q;
        p2m_d          = p2m_q;
        round_result_d = round_result_q;
        result_valid_d = 1'b0;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_cnt_d    = round_cnt_q;
        match_done_d   = match_done_q;
        match_winner_d = match_winner_q;
        if (clear_i) begin
            state_d        = IDLE;
            round_result_d = RES_TIE;
            p1_score_d     = '0;
            p2_score_d     = '0;
            round_cnt_d    = '0;
            match_done_d   = 1'b0;
            match_winner_d = 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        p1m_d   = p1_move_i;
                        p2m_d   = p2_move_i;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    round_result_d = verdict;
                    result_valid_d = 1'b1;
                    if (verdict == RES_P1 && p1_score_q != CNT_MAX)
                        p1_score_d = p1_score_q + 1'b1;
                    if (verdict == RES_P2 && p2_score_q != CNT_MAX)
                        p2_score_d = p2_score_q + 1'b1;
                    if (verdict != RES_INV && round_cnt_q != CNT_MAX)
                        round_cnt_d = round_cnt_q + 1'b1;
                    state_d = RESULT;
                end
                RESULT: begin
                    if (!start_i) begin
                        if (end_cond) begin
                            state_d      = DONE;
                            match_done_d = 1'b1;
                            if (p1_score_q > p2_score_q)
                                match_winner_d = 2'b01;
                            else if (p2_score_q > p1_score_q)
                                match_winner_d = 2'b10;
                            else
                                match_winner_d = 2'b00;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; start_d tracks start unconditionally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            start_d_q      <= 1'b0;
            p1m_q          <= 2'b00;
            p2m_q          <= 2'b00;
            round_result_q <= 2'b00;
            result_valid_q <= 1'b0;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_cnt_q    <= '0;
            match_done_q   <= 1'b0;
            match_winner_q <= 2'b00;
        end else begin
            state_q        <= state_d;
            start_d_q      <= start_i;
            p1m_q          <= p1m_d;
            p2m_q          <= p2m_d;
            round_result_q <= round_result_d;
            result_valid_q <= result_valid_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_cnt_q    <= round_cnt_d;
            match_done_q   <= match_done_d;
            match_winner_q <= match_winner_d;
        end
    end

    assign round_result_o = round_result_q;
    assign result_valid_o = result_valid_q;
    assign p1_score_o     = p1_score_q;
    assign p2_score_o     = p2_score_q;
    assign round_cnt_o    = round_cnt_q;
    assign match_done_o   = match_done_q;
    assign match_winner_o = match_winner_q;

endmodule
